layer_wr_ctl: RTL and testbench

Command decoder that sits directly upstream of the per-layer WS2812 output stage.
- Consumes a byte stream from the SPI slave: one pulse per received byte, plus one pulse at frame end (chip-select release).
- Decodes configuration, address and pixel-data commands.
- Drives the pixel write interface (en/done/addr/data/byte-enable) and the bit-timing count registers of the output stage.

---
 rtl/layer_wr_pkg.sv | 19 +
 rtl/layer_wr_ctl.sv | 162 ++++++++++++++++
 tb/tb_layer_wr_ctl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/layer_wr_pkg.sv
// rtl/layer_wr_pkg.sv - command codes, FSM state type and config length for layer_wr_ctl
package layer_wr_pkg;

  localparam logic [7:0] CMD_CONF_WR = 8'h2A;
  localparam logic [7:0] CMD_ADDR_WR = 8'h2B;
  localparam logic [7:0] CMD_DATA_WR = 8'h2C;

  // Number of payload bytes in a CONF frame: t0h, t0l, t1h, t1l, rst_hi, rst_lo
  localparam logic [2:0] CONF_LEN = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONF,
    ST_ADDR,
    ST_DATA,
    ST_DISCARD
  } state_t;

endpackage

// File: rtl/layer_wr_ctl.sv
// rtl/layer_wr_ctl.sv - SPI byte-stream command decoder driving the WS2812 layer write port
//
// Ports:
//   clk_in, rst_n_in        clock, asynchronous active-low reset
//   byte_rdy_in/byte_data_in one-cycle byte strobe and received byte
//   frame_end_in            one-cycle strobe at chip-select release
//   wr_en_out/wr_done_out   pixel byte write strobe / end-of-frame refresh strobe
//   wr_addr_out/wr_data_out/wr_byte_en_out  pixel address, byte, one-hot lane
//   t0h/t0l/t1h/t1l_cnt_out, rst_cnt_out    bit-timing and latch counts
module layer_wr_ctl
  import layer_wr_pkg::*;
#(
  parameter int          ADDR_W  = 6,
  parameter int          LANES   = 3,
  parameter logic [7:0]  T0H_DEF = 8'd16,
  parameter logic [7:0]  T0L_DEF = 8'd48,
  parameter logic [7:0]  T1H_DEF = 8'd48,
  parameter logic [7:0]  T1L_DEF = 8'd16,
  parameter logic [15:0] RST_DEF = 16'd4000
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              byte_rdy_in,
  input  logic [7:0]        byte_data_in,
  input  logic              frame_end_in,
  output logic              wr_en_out,
  output logic              wr_done_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [7:0]        wr_data_out,
  output logic [3:0]        wr_byte_en_out,
  output logic [7:0]        t0h_cnt_out,
  output logic [7:0]        t0l_cnt_out,
  output logic [7:0]        t1h_cnt_out,
  output logic [7:0]        t1l_cnt_out,
  output logic [15:0]       rst_cnt_out
);

  state_t            st;
  logic              sync_lost;   // set by reset: frame alignment unknown until next frame end
  logic [2:0]        cnt;         // payload bytes seen in CONF/ADDR, saturates at CONF_LEN
  logic [7:0]        sh_t0h, sh_t0l, sh_t1h, sh_t1l, sh_rst_hi;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] cur_addr;
  logic [1:0]        lane;
  logic              wrote;       // at least one pixel byte written in this DATA frame
  logic              done_pend;   // frame end coincided with a data byte: done one cycle later

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      st             <= ST_IDLE;
      sync_lost      <= 1'b1;
      cnt            <= '0;
      sh_t0h         <= '0;
      sh_t0l         <= '0;
      sh_t1h         <= '0;
      sh_t1l         <= '0;
      sh_rst_hi      <= '0;
      start_addr     <= '0;
      cur_addr       <= '0;
      lane           <= '0;
      wrote          <= 1'b0;
      done_pend      <= 1'b0;
      wr_en_out      <= 1'b0;
      wr_done_out    <= 1'b0;
      wr_addr_out    <= '0;
      wr_data_out    <= '0;
      wr_byte_en_out <= '0;
      t0h_cnt_out    <= T0H_DEF;
      t0l_cnt_out    <= T0L_DEF;
      t1h_cnt_out    <= T1H_DEF;
      t1l_cnt_out    <= T1L_DEF;
      rst_cnt_out    <= RST_DEF;
    end else begin
      wr_en_out   <= 1'b0;
      wr_done_out <= done_pend;
      done_pend   <= 1'b0;

      if (byte_rdy_in) begin
        case (st)
          ST_IDLE: begin
            cnt <= '0;
            if (sync_lost) begin
              st <= ST_DISCARD;
            end else begin
              case (byte_data_in)
                CMD_CONF_WR: st <= ST_CONF;
                CMD_ADDR_WR: st <= ST_ADDR;
                CMD_DATA_WR: begin
                  st       <= ST_DATA;
                  cur_addr <= start_addr;
                  lane     <= '0;
                  wrote    <= 1'b0;
                end
                default:     st <= ST_DISCARD;
              endcase
            end
          end

          ST_CONF: begin
            if (cnt < CONF_LEN) begin
              cnt <= cnt + 3'd1;
              case (cnt)
                3'd0: sh_t0h    <= byte_data_in;
                3'd1: sh_t0l    <= byte_data_in;
                3'd2: sh_t1h    <= byte_data_in;
                3'd3: sh_t1l    <= byte_data_in;
                3'd4: sh_rst_hi <= byte_data_in;
                default: begin
                  // Last byte: all five counts change on the same edge
                  t0h_cnt_out <= sh_t0h;
                  t0l_cnt_out <= sh_t0l;
                  t1h_cnt_out <= sh_t1h;
                  t1l_cnt_out <= sh_t1l;
                  rst_cnt_out <= {sh_rst_hi, byte_data_in};
                end
              endcase
            end
          end

          ST_ADDR: begin
            if (cnt == 3'd0) begin
              start_addr <= byte_data_in[ADDR_W-1:0];
              cnt        <= 3'd1;
            end
          end

          ST_DATA: begin
            wr_en_out      <= 1'b1;
            wr_data_out    <= byte_data_in;
            wr_addr_out    <= cur_addr;
            wr_byte_en_out <= 4'b0001 << lane;
            wrote          <= 1'b1;
            if (lane == 2'(LANES - 1)) begin
              lane     <= '0;
              cur_addr <= cur_addr + 1'b1;
            end else begin
              lane <= lane + 2'd1;
            end
          end

          default: ;
        endcase
      end

      // Frame end overrides the state update above; a byte on the same
      // cycle has already been processed.
      if (frame_end_in) begin
        st        <= ST_IDLE;
        cnt       <= '0;
        sync_lost <= 1'b0;
        if (st == ST_DATA) begin
          if (byte_rdy_in) begin
            done_pend <= 1'b1;
          end else begin
            wr_done_out <= wrote;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_layer_wr_ctl.sv
// tb/tb_layer_wr_ctl.sv - directed self-checking bench for layer_wr_ctl
module tb_layer_wr_ctl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       byte_rdy;
  logic [7:0] byte_data;
  logic       frame_end;
  logic       wr_en, wr_done;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] wr_byte_en;
  logic [7:0] t0h, t0l, t1h, t1l;
  logic [15:0] rst_cnt;

  int vectors = 0;
  int miscompares = 0;

  int cyc = 0, en_cnt = 0, done_cnt = 0, both_hi = 0, last_en_cyc = -1, done_cyc = -1;
  logic [5:0] q_addr[$];
  logic [3:0] q_en[$];
  logic [7:0] q_data[$];

  always #5 clk = ~clk;

  layer_wr_ctl dut (
    .clk_in(clk), .rst_n_in(rst_n), .byte_rdy_in(byte_rdy), .byte_data_in(byte_data),
    .frame_end_in(frame_end), .wr_en_out(wr_en), .wr_done_out(wr_done),
    .wr_addr_out(wr_addr), .wr_data_out(wr_data), .wr_byte_en_out(wr_byte_en),
    .t0h_cnt_out(t0h), .t0l_cnt_out(t0l), .t1h_cnt_out(t1h), .t1l_cnt_out(t1l),
    .rst_cnt_out(rst_cnt)
  );

  always @(negedge clk) begin
    cyc++;
    if (wr_en === 1'b1) begin
      en_cnt++;
      last_en_cyc = cyc;
      q_addr.push_back(wr_addr);
      q_en.push_back(wr_byte_en);
      q_data.push_back(wr_data);
    end
    if (wr_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (wr_en === 1'b1 && wr_done === 1'b1) both_hi++;
  end

  task automatic clear_log();
    q_addr.delete(); q_en.delete(); q_data.delete();
    en_cnt = 0; done_cnt = 0; last_en_cyc = -1; done_cyc = -1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_rdy = 1'b1; byte_data = b;
    @(negedge clk);
    byte_rdy = 1'b0;
  endtask

  task automatic send_end();
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
  endtask

  task automatic send_byte_end(input logic [7:0] b);
    byte_rdy = 1'b1; frame_end = 1'b1; byte_data = b;
    @(negedge clk);
    byte_rdy = 1'b0; frame_end = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; byte_rdy = 1'b0; frame_end = 1'b0; byte_data = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (t0h !== 8'd16) begin miscompares++; $display("FAIL reset_t0h: got %0d expected 16", t0h); end
    vectors++; if (t0l !== 8'd48) begin miscompares++; $display("FAIL reset_t0l: got %0d expected 48", t0l); end
    vectors++; if (t1h !== 8'd48) begin miscompares++; $display("FAIL reset_t1h: got %0d expected 48", t1h); end
    vectors++; if (t1l !== 8'd16) begin miscompares++; $display("FAIL reset_t1l: got %0d expected 16", t1l); end
    vectors++; if (rst_cnt !== 16'd4000) begin miscompares++; $display("FAIL reset_rst: got %0d expected 4000", rst_cnt); end
    vectors++; if ({wr_en, wr_done, wr_addr, wr_data, wr_byte_en} !== 20'h0) begin
      miscompares++; $display("FAIL reset_wr_port: got en=%b done=%b addr=%0h data=%0h be=%b expected all 0", wr_en, wr_done, wr_addr, wr_data, wr_byte_en);
    end
    clear_log();
    send_end();
    settle();
    vectors++; if (en_cnt + done_cnt !== 0) begin miscompares++; $display("FAIL empty_frame_strobes: got %0d expected 0", en_cnt + done_cnt); end
  endtask

  task automatic test_conf();
    logic [7:0] cb [7] = '{8'h2A, 8'h0A, 8'h1E, 8'h1E, 8'h0A, 8'h01, 8'hF4};
    for (int i = 0; i < 6; i++) send_byte(cb[i]);
    vectors++; if (rst_cnt !== 16'd4000) begin miscompares++; $display("FAIL conf_early_commit: got rst=%0d expected 4000", rst_cnt); end
    send_byte(cb[6]);
    vectors++; if ({t0h, t0l, t1h, t1l} !== {8'd10, 8'd30, 8'd30, 8'd10}) begin
      miscompares++; $display("FAIL conf_timing: got %0d,%0d,%0d,%0d expected 10,30,30,10", t0h, t0l, t1h, t1l);
    end
    vectors++; if (rst_cnt !== 16'd500) begin miscompares++; $display("FAIL conf_rst: got %0d expected 500", rst_cnt); end
    send_end();
    send_byte(8'h2A); send_byte(8'h05); send_byte(8'h05);
    send_end();
    settle();
    vectors++; if ({t0h, t0l, t1h, t1l, rst_cnt} !== {8'd10, 8'd30, 8'd30, 8'd10, 16'd500}) begin
      miscompares++; $display("FAIL conf_truncated: got %0d,%0d,%0d,%0d,%0d expected 10,30,30,10,500", t0h, t0l, t1h, t1l, rst_cnt);
    end
  endtask

  task automatic test_data_write();
    logic [5:0] ea [6] = '{6'd62, 6'd62, 6'd62, 6'd63, 6'd63, 6'd63};
    logic [3:0] ee [6] = '{4'b001, 4'b010, 4'b100, 4'b001, 4'b010, 4'b100};
    clear_log();
    send_byte(8'h2B); send_byte(8'h3E); send_end();
    send_byte(8'h2C);
    for (int i = 0; i < 6; i++) send_byte(8'h11 + 8'(i));
    send_end();
    settle();
    vectors++; if (en_cnt !== 6) begin miscompares++; $display("FAIL data_count: got %0d expected 6", en_cnt); end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (q_addr[i] !== ea[i] || q_en[i] !== ee[i] || q_data[i] !== 8'h11 + 8'(i)) begin
        miscompares++; $display("FAIL data_write%0d: got addr=%0d be=%b data=%0h expected addr=%0d be=%b data=%0h",
                                i, q_addr[i], q_en[i], q_data[i], ea[i], ee[i], 8'h11 + 8'(i));
      end
    end
    vectors++; if (done_cnt !== 1 || done_cyc !== last_en_cyc + 1) begin
      miscompares++; $display("FAIL data_done: got count=%0d at cycle %0d expected 1 at cycle %0d", done_cnt, done_cyc, last_en_cyc + 1);
    end
  endtask

  task automatic test_wrap();
    logic [5:0] ea [4] = '{6'd63, 6'd63, 6'd63, 6'd0};
    logic [3:0] ee [4] = '{4'b001, 4'b010, 4'b100, 4'b001};
    clear_log();
    send_byte(8'h2B); send_byte(8'h3F); send_end();
    send_byte(8'h2C);
    for (int i = 0; i < 4; i++) send_byte(8'h21 + 8'(i));
    send_end();
    settle();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (q_addr[i] !== ea[i] || q_en[i] !== ee[i]) begin
        miscompares++; $display("FAIL wrap_write%0d: got addr=%0d be=%b expected addr=%0d be=%b", i, q_addr[i], q_en[i], ea[i], ee[i]);
      end
    end
    vectors++; if (en_cnt !== 4 || done_cnt !== 1) begin
      miscompares++; $display("FAIL wrap_counts: got writes=%0d done=%0d expected 4 and 1", en_cnt, done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    send_byte(8'h2C); send_byte(8'hA1);
    send_byte_end(8'hA2);
    vectors++; if ({wr_en, wr_done, wr_data, wr_byte_en} !== {1'b1, 1'b0, 8'hA2, 4'b010}) begin
      miscompares++; $display("FAIL same_cycle_n1: got en=%b done=%b data=%0h be=%b expected 1 0 a2 0010", wr_en, wr_done, wr_data, wr_byte_en);
    end
    @(negedge clk);
    vectors++; if ({wr_en, wr_done} !== 2'b01) begin
      miscompares++; $display("FAIL same_cycle_n2: got en=%b done=%b expected 0 1", wr_en, wr_done);
    end
    settle();
    clear_log();
    send_byte(8'h2C); send_end();
    send_byte(8'h55); send_byte(8'h2C); send_byte(8'h11); send_end();
    settle();
    vectors++; if (done_cnt !== 0) begin miscompares++; $display("FAIL empty_data_done: got %0d expected 0", done_cnt); end
    vectors++; if (en_cnt !== 0) begin miscompares++; $display("FAIL unknown_cmd_writes: got %0d expected 0", en_cnt); end
    vectors++; if (both_hi !== 0) begin miscompares++; $display("FAIL en_done_overlap: got %0d expected 0", both_hi); end
  endtask

  task automatic test_reset_mid_frame();
    send_byte(8'h2C); send_byte(8'h01); send_byte(8'h02);
    rst_n = 1'b0;
    #1;
    vectors++; if ({wr_en, wr_addr, wr_data, wr_byte_en} !== 19'h0) begin
      miscompares++; $display("FAIL midreset_port: got en=%b addr=%0d data=%0h be=%b expected all 0", wr_en, wr_addr, wr_data, wr_byte_en);
    end
    vectors++; if ({t0h, rst_cnt} !== {8'd16, 16'd4000}) begin
      miscompares++; $display("FAIL midreset_timing: got t0h=%0d rst=%0d expected 16 4000", t0h, rst_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_log();
    send_byte(8'h03); send_byte(8'h04); send_end();
    settle();
    vectors++; if (en_cnt + done_cnt !== 0) begin miscompares++; $display("FAIL midreset_tail: got %0d strobes expected 0", en_cnt + done_cnt); end
    send_byte(8'h2C); send_byte(8'h77); send_end();
    settle();
    vectors++; if (en_cnt !== 1 || q_addr[0] !== 6'd0 || q_en[0] !== 4'b001 || q_data[0] !== 8'h77 || done_cnt !== 1) begin
      miscompares++; $display("FAIL midreset_next_frame: got writes=%0d addr=%0d be=%b data=%0h done=%0d expected 1 0 0001 77 1",
                              en_cnt, q_addr[0], q_en[0], q_data[0], done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_conf();
    test_data_write();
    test_wrap();
    test_back_to_back();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
